// File: rtl/ex_operand_stage.sv
// ex_operand_stage: decode-to-execute pipeline register.
// Resolves ALU source operands from the register file, the EX/WB
// forwarding paths and the immediate field. It detects load-use hazards
// and inserts a single bubble for each one. It honours downstream stall
// and flush. All ALU-facing outputs are registered.
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA   = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_alu_control,
    input  logic [RA-1:0]   in_rs,
    input  logic [RA-1:0]   in_rt,
    input  logic [XLEN-1:0] in_rs_data,
    input  logic [XLEN-1:0] in_rt_data,
    input  logic [15:0]     in_imm,
    input  logic            in_imm_sel,
    input  logic            in_imm_zext,
    input  logic [RA-1:0]   in_rd,
    input  logic            in_wb_en,
    input  logic            ex_wb_en,
    input  logic [RA-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_is_load,
    input  logic            wb_en,
    input  logic [RA-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            out_ready,
    input  logic            flush,
    output logic            out_valid,
    output logic [2:0]      alu_control,
    output logic [XLEN-1:0] srcA,
    output logic [XLEN-1:0] srcB,
    output logic [RA-1:0]   out_rd,
    output logic            out_wb_en
);

    logic [XLEN-1:0] imm_ext_s;
    logic [XLEN-1:0] opa_s;
    logic [XLEN-1:0] rt_val_s;
    logic [XLEN-1:0] opb_s;
    logic            rs_dep_s;
    logic            rt_dep_s;
    logic            hazard_s;
    logic            advance_s;

    logic            out_valid_r;
    logic [2:0]      alu_control_r;
    logic [XLEN-1:0] srca_r;
    logic [XLEN-1:0] srcb_r;
    logic [RA-1:0]   out_rd_r;
    logic            out_wb_en_r;

    // Forwarding priority for one source: r0 first, then EX (non-load), then WB, then the register file.
    function automatic logic [XLEN-1:0] resolve_operand(
        input logic [RA-1:0]   idx,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_en,
        input logic            ex_load,
        input logic [RA-1:0]   ex_idx,
        input logic [XLEN-1:0] ex_val,
        input logic            wb_on,
        input logic [RA-1:0]   wb_idx,
        input logic [XLEN-1:0] wb_val
    );
        logic [XLEN-1:0] val;
        if (idx == {RA{1'b0}}) begin
            val = {XLEN{1'b0}};
        end else if (ex_en && !ex_load && (ex_idx == idx)) begin
            val = ex_val;
        end else if (wb_on && (wb_idx == idx)) begin
            val = wb_val;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Immediate extension: zero- or sign-extend the 16-bit field to XLEN.
    always_comb begin
        imm_ext_s = {XLEN{1'b0}};
        if (in_imm_zext) begin
            imm_ext_s = {{(XLEN-16){1'b0}}, in_imm};
        end else begin
            imm_ext_s = {{(XLEN-16){in_imm[15]}}, in_imm};
        end
    end

    // Operand resolution: forward both sources, then choose B between rt and the immediate.
    always_comb begin
        opa_s    = resolve_operand(in_rs, in_rs_data, ex_wb_en, ex_is_load, ex_rd,
                                   ex_result, wb_en, wb_rd, wb_data);
        rt_val_s = resolve_operand(in_rt, in_rt_data, ex_wb_en, ex_is_load, ex_rd,
                                   ex_result, wb_en, wb_rd, wb_data);
        opb_s    = rt_val_s;
        if (in_imm_sel) begin
            opb_s = imm_ext_s;
        end else begin
            opb_s = rt_val_s;
        end
    end

    // Load-use detection: a load in EX cannot forward, so a consumer must wait one cycle.
    always_comb begin
        rs_dep_s = (ex_rd == in_rs);
        rt_dep_s = 1'b0;
        if (in_imm_sel) begin
            rt_dep_s = 1'b0;
        end else begin
            rt_dep_s = (ex_rd == in_rt);
        end
        hazard_s  = in_valid && ex_wb_en && ex_is_load && (ex_rd != {RA{1'b0}})
                    && (rs_dep_s || rt_dep_s);
        advance_s = out_ready || !out_valid_r;
    end

    assign in_ready = advance_s && !hazard_s && !flush;

    // Pipeline register: reset, flush, capture/bubble when advancing, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_r   <= 1'b0;
            alu_control_r <= 3'b000;
            srca_r        <= {XLEN{1'b0}};
            srcb_r        <= {XLEN{1'b0}};
            out_rd_r      <= {RA{1'b0}};
            out_wb_en_r   <= 1'b0;
        end else if (flush) begin
            out_valid_r   <= 1'b0;
            out_wb_en_r   <= 1'b0;
        end else if (advance_s) begin
            if (in_valid && !hazard_s) begin
                out_valid_r   <= 1'b1;
                alu_control_r <= in_alu_control;
                srca_r        <= opa_s;
                srcb_r        <= opb_s;
                out_rd_r      <= in_rd;
                out_wb_en_r   <= in_wb_en;
            end else begin
                out_valid_r   <= 1'b0;
                out_wb_en_r   <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_r;
    assign alu_control = alu_control_r;
    assign srcA        = srca_r;
    assign srcB        = srcb_r;
    assign out_rd      = out_rd_r;
    assign out_wb_en   = out_wb_en_r;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the stage.
module tb_ex_operand_stage;
    localparam int XLEN = 32;
    localparam int RA   = 5;

    logic            clk = 1'b0;
    logic            rstn;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_alu_control;
    logic [RA-1:0]   in_rs, in_rt, in_rd;
    logic [XLEN-1:0] in_rs_data, in_rt_data;
    logic [15:0]     in_imm;
    logic            in_imm_sel, in_imm_zext, in_wb_en;
    logic            ex_wb_en, ex_is_load;
    logic [RA-1:0]   ex_rd;
    logic [XLEN-1:0] ex_result;
    logic            wb_en;
    logic [RA-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_ready, flush;
    logic            out_valid;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] srcA, srcB;
    logic [RA-1:0]   out_rd;
    logic            out_wb_en;

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(XLEN), .RA(RA)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_control(in_alu_control), .in_rs(in_rs), .in_rt(in_rt),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_imm_sel(in_imm_sel), .in_imm_zext(in_imm_zext), .in_rd(in_rd),
        .in_wb_en(in_wb_en), .ex_wb_en(ex_wb_en), .ex_rd(ex_rd),
        .ex_result(ex_result), .ex_is_load(ex_is_load), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .out_ready(out_ready), .flush(flush),
        .out_valid(out_valid), .alu_control(alu_control), .srcA(srcA),
        .srcB(srcB), .out_rd(out_rd), .out_wb_en(out_wb_en)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state: what the ALU should currently be seeing.
    logic            m_init = 1'b0;
    logic            m_valid = 1'b0;
    logic [2:0]      m_alu;
    logic [XLEN-1:0] m_a, m_b;
    logic [RA-1:0]   m_rd;
    logic            m_wb = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Value a source register should have given the current bypass inputs.
    function automatic logic [XLEN-1:0] ref_operand(input logic [RA-1:0] idx, input logic [XLEN-1:0] rf);
        if (idx == 0) return 0;
        if (ex_wb_en && !ex_is_load && ex_rd == idx) return ex_result;
        if (wb_en && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        return in_valid && ex_wb_en && ex_is_load && (ex_rd != 0) &&
               (ex_rd == in_rs || (!in_imm_sel && ex_rd == in_rt));
    endfunction

    function automatic logic [XLEN-1:0] ref_imm();
        if (in_imm_zext) return XLEN'(in_imm);
        return XLEN'($signed(in_imm));
    endfunction

    // One clock: check in_ready, advance the model on the edge, check outputs.
    task automatic cyc();
        logic hz, adv, exp_ready;
        #1;
        hz  = ref_hazard();
        adv = out_ready || !m_valid;
        exp_ready = adv && !hz && !flush;
        if (m_init && rstn) check("in_ready", in_ready, exp_ready);
        @(posedge clk);
        if (!rstn) begin
            m_valid = 0; m_alu = 0; m_a = 0; m_b = 0; m_rd = 0; m_wb = 0; m_init = 1;
        end else if (m_init) begin
            if (flush) begin
                m_valid = 0; m_wb = 0;
            end else if (adv) begin
                if (in_valid && !hz) begin
                    m_valid = 1;
                    m_alu   = in_alu_control;
                    m_a     = ref_operand(in_rs, in_rs_data);
                    m_b     = in_imm_sel ? ref_imm() : ref_operand(in_rt, in_rt_data);
                    m_rd    = in_rd;
                    m_wb    = in_wb_en;
                end else begin
                    m_valid = 0; m_wb = 0;
                end
            end
        end
        #1;
        if (m_init) begin
            check("out_valid", out_valid, m_valid);
            check("out_wb_en", out_wb_en, m_wb);
            if (m_valid) begin
                check("alu_control", alu_control, m_alu);
                check("srcA", srcA, m_a);
                check("srcB", srcB, m_b);
                check("out_rd", out_rd, m_rd);
            end
        end
    endtask

    task automatic drive_idle();
        in_valid = 0; in_alu_control = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_imm_sel = 0;
        in_imm_zext = 0; in_wb_en = 0; ex_wb_en = 0; ex_rd = 0; ex_result = 0;
        ex_is_load = 0; wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 1; flush = 0;
    endtask

    task automatic drive_random();
        in_valid       = ($urandom_range(9, 0) < 8);
        in_alu_control = 3'($urandom);
        in_rs          = RA'($urandom_range(3, 0));
        in_rt          = RA'($urandom_range(3, 0));
        in_rd          = RA'($urandom_range(3, 0));
        in_rs_data     = $urandom;
        in_rt_data     = $urandom;
        in_imm         = 16'($urandom);
        in_imm_sel     = 1'($urandom);
        in_imm_zext    = 1'($urandom);
        in_wb_en       = 1'($urandom);
        ex_wb_en       = 1'($urandom);
        ex_rd          = RA'($urandom_range(3, 0));
        ex_result      = $urandom;
        ex_is_load     = ($urandom_range(9, 0) < 3);
        wb_en          = 1'($urandom);
        wb_rd          = RA'($urandom_range(3, 0));
        wb_data        = $urandom;
        out_ready      = ($urandom_range(3, 0) != 0);
        flush          = ($urandom_range(19, 0) == 0);
        rstn           = ($urandom_range(49, 0) != 0);
    endtask

    initial begin
        drive_idle();
        // Reset held for two cycles with a live input.
        rstn = 0; in_valid = 1; in_alu_control = 3'd5; in_rs = 1; in_rs_data = 32'h55;
        cyc(); cyc();
        check("rst_valid", out_valid, 0);
        check("rst_srcA", srcA, 0);
        check("rst_srcB", srcB, 0);
        check("rst_alu", alu_control, 0);

        // Immediate extension; the first capture follows release.
        rstn = 1; in_imm = 16'h8001; in_imm_sel = 1; in_imm_zext = 0;
        cyc();
        check("first_capture", out_valid, 1);
        check("imm_sext", srcB, 32'hFFFF8001);
        in_imm_zext = 1;
        cyc();
        check("imm_zext", srcB, 32'h00008001);

        // Forwarding priority.
        in_imm_sel = 0; in_rs = 3; ex_wb_en = 1; ex_is_load = 0; ex_rd = 3; ex_result = 5;
        wb_en = 1; wb_rd = 3; wb_data = 7; in_rs_data = 9;
        cyc();
        check("fwd_ex", srcA, 5);
        ex_wb_en = 0;
        cyc();
        check("fwd_wb", srcA, 7);
        ex_wb_en = 1; in_rs = 0;
        cyc();
        check("fwd_r0", srcA, 0);

        // Load-use: one bubble, then the operand comes from WB.
        ex_wb_en = 1; ex_is_load = 1; ex_rd = 4; wb_en = 0;
        in_rs = 1; in_rs_data = 11; in_rt = 4; in_rt_data = 22; in_imm_sel = 0;
        #1 check("lu_ready", in_ready, 0);
        cyc();
        check("lu_bubble", out_valid, 0);
        ex_wb_en = 0; ex_is_load = 0; wb_en = 1; wb_rd = 4; wb_data = 33;
        #1 check("lu_ready2", in_ready, 1);
        cyc();
        check("lu_valid", out_valid, 1);
        check("lu_srcB", srcB, 33);
        ex_wb_en = 1; ex_is_load = 1; ex_rd = 4; wb_en = 0; in_imm_sel = 1;
        #1 check("lu_imm_ready", in_ready, 1);
        cyc();
        check("lu_imm_valid", out_valid, 1);

        // Stall hold for three cycles, then release.
        drive_idle(); in_valid = 1; in_rs = 2; in_rs_data = 100; in_alu_control = 3'd2;
        cyc();
        out_ready = 0; in_rs_data = 200; in_alu_control = 3'd6;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_ready", in_ready, 0);
            cyc();
            check("stall_srcA", srcA, 100);
            check("stall_alu", alu_control, 2);
        end
        out_ready = 1;
        cyc();
        check("release_srcA", srcA, 200);
        check("release_alu", alu_control, 6);

        // Flush beats capture, and the dropped input never appears.
        flush = 1; in_rs_data = 300;
        #1 check("flush_ready", in_ready, 0);
        cyc();
        check("flush_valid", out_valid, 0);
        flush = 0; in_valid = 0;
        cyc();
        check("flush_drop", out_valid, 0);

        // Flush while stalled, and reset while stalled.
        in_valid = 1; cyc();
        out_ready = 0; flush = 1; cyc();
        check("flush_stalled", out_valid, 0);
        flush = 0; out_ready = 1; cyc();
        out_ready = 0; rstn = 0; cyc();
        check("rst_stalled", out_valid, 0);
        rstn = 1;

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            drive_random();
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Decode-to-execute pipeline register with operand selection and forwarding, sitting directly upstream of the core's 3-bit-control ALU. It captures a decoded instruction, resolves source operands from register-file data, EX/WB forwarding paths and the immediate field, and presents registered `alu_control`/`srcA`/`srcB` to the ALU. It also detects load-use hazards, inserts bubbles, and honours downstream stall and flush.

## Interface
- `XLEN`, default 32: datapath width.
- `RA`, default 5: register index width. Register 0 reads as constant zero.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage accepts this cycle (combinational).
- `in_alu_control`  in  3  ALU opcode, passed through.
- `in_rs`, `in_rt`  in  RA  source register indices.
- `in_rs_data`, `in_rt_data`  in  XLEN  register-file read data.
- `in_imm`  in  16  immediate field.
- `in_imm_sel`  in  1  1: `srcB` comes from the immediate; `rt` is not a source.
- `in_imm_zext`  in  1  1: zero-extend the immediate; 0: sign-extend it.
- `in_rd`  in  RA  destination register.
- `in_wb_en`  in  1  instruction writes `rd`.
- `ex_wb_en`, `ex_rd`, `ex_result`, `ex_is_load`  in  1/RA/XLEN/1  instruction currently in EX (the one held in this stage's output).
- `wb_en`, `wb_rd`, `wb_data`  in  1/RA/XLEN  write-back stage.
- `out_ready`  in  1  downstream can advance.
- `flush`  in  1  kill the held instruction and the incoming one.
- `out_valid`  out  1  outputs hold a live instruction.
- `alu_control`  out  3; `srcA`, `srcB`  out  XLEN; `out_rd`  out  RA; `out_wb_en`  out  1.

## Operation
- **Immediate:** `imm_ext = in_imm_zext ? {16'b0, in_imm} : {{16{in_imm[15]}}, in_imm}`.
- **Operand A:** selected from `in_rs`.
- **Operand B:** selected from `in_rt` when `in_imm_sel=0`, otherwise `imm_ext`.
- **Per-source forwarding priority:**
  1. Index 0 gives 0.
  2. Else `ex_wb_en && !ex_is_load && ex_rd==idx` gives `ex_result`.
  3. Else `wb_en && wb_rd==idx` gives `wb_data`.
  4. Else register-file data.
- **Hazard:** `hazard = in_valid && ex_wb_en && ex_is_load && ex_rd!=0 && (ex_rd==in_rs || (!in_imm_sel && ex_rd==in_rt))`.
- **Ready:** `in_ready = (out_ready || !out_valid) && !hazard && !flush`.
- **Register update, in priority order:**
  1. `!rstn`: all outputs 0, `out_valid=0`.
  2. `flush`: `out_valid<=0`; other outputs don't-care.
  3. `out_ready || !out_valid`:
     - `in_valid && !hazard`: capture `alu_control`, resolved `srcA`/`srcB`, `out_rd`, `out_wb_en`; set `out_valid<=1`.
     - Otherwise: `out_valid<=0` (bubble); `out_wb_en<=0`.
  4. Otherwise (stalled): hold every output.
- `ex_*` and `wb_*` are sampled only on capture cycles. Held operands are never re-resolved.
- When `out_valid=0`, `out_wb_en` is always 0, so a bubble never forwards.

## Timing
- Latency is 1 cycle from an accepted input to the registered outputs. Throughput is 1 instruction per cycle with no hazard.
- A load-use hazard costs exactly 1 bubble:
  - Cycle n: `in_ready=0`, and a bubble is written.
  - Cycle n+1: the load has moved to WB, so the operand is taken from `wb_data`, and `in_ready=1`.
- Flush and capture in the same cycle: flush wins and the input is dropped.
- Flush takes effect while stalled.
- Reset mid-stall clears `out_valid` on the next edge.
- Simultaneous EX and WB match on the same index: EX wins.

## Test plan
- **Reset:** `rstn=0` for 2 cycles with `in_valid=1` → `out_valid=0`, `srcA=srcB=0`, `alu_control=0`. The first capture happens only after release.
- **Immediate extension:** `in_imm=16'h8001`, `in_imm_sel=1`.
  - `in_imm_zext=0` → `srcB=32'hFFFF8001`.
  - `in_imm_zext=1` → `srcB=32'h00008001`.
- **Forwarding priority:** `in_rs=3`, `ex_rd=3` with `ex_result=5`, `wb_rd=3` with `wb_data=7`, `in_rs_data=9` → `srcA=5`.
  - Drop `ex_wb_en` → `srcA=7`.
  - `in_rs=0` → `srcA=0` regardless of forwarding.
- **Load-use:** EX holds a load to r4 and the next instruction reads `rt=4` with `in_imm_sel=0` → `in_ready=0`, one cycle with `out_valid=0`. The following cycle captures `srcB=wb_data`.
  - Same case with `in_imm_sel=1` → no stall.
- **Stall hold:** `out_ready=0` for 3 cycles with a new `in_valid` → outputs unchanged and `in_ready=0`. After release, the new instruction appears 1 cycle later.
- **Flush:** `flush=1` with `in_valid=1` and `out_ready=1` → next cycle `out_valid=0`, and the input is not captured.
